// File: rtl/tia_playfield_serializer.sv
// TIA playfield serializer: turns the PF0/PF1/PF2 registers and the CTRLPF
// reflect bit into the one-bit-per-pixel playfield stream for a 160-pixel line.
module tia_playfield_serializer (
    input  logic       clk,
    input  logic       reset,
    input  logic       pix_en,
    input  logic       hblank,
    input  logic       pf0_we,
    input  logic       pf1_we,
    input  logic       pf2_we,
    input  logic       ctrlpf_we,
    input  logic [7:0] wdata,
    output logic       pf,
    output logic [4:0] pf_bit,
    output logic       pf_right,
    output logic       line_done,
    output logic [1:0] fsm_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t     state, state_nx;
    logic [3:0] pf0_q;
    logic [7:0] pf1_q, pf2_q;
    logic       ref_q;

    logic [1:0] sub, sub_nx;
    logic [4:0] pos, pos_nx;
    logic       half, half_nx;

    logic       pf_nx, pf_right_nx, line_done_nx;
    logic [4:0] pf_bit_nx;
    logic [4:0] n_sel, idx1, idx2;
    logic       bit_val;

    assign fsm_state = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pf0_q <= '0;
            pf1_q <= '0;
            pf2_q <= '0;
            ref_q <= 1'b0;
        end else begin
            if (pf0_we)    pf0_q <= wdata[7:4];
            if (pf1_we)    pf1_q <= wdata;
            if (pf2_we)    pf2_q <= wdata;
            if (ctrlpf_we) ref_q <= wdata[0];
        end
    end

    // Bit index mapping: PF0 high nibble LSB-first, PF1 MSB-first, PF2 LSB-first.
    always_comb begin
        n_sel   = (half && ref_q) ? (5'd19 - pos) : pos;
        idx1    = 5'd11 - n_sel;
        idx2    = n_sel - 5'd12;
        bit_val = 1'b0;
        if (n_sel < 5'd4)
            bit_val = pf0_q[n_sel[1:0]];
        else if (n_sel < 5'd12)
            bit_val = pf1_q[idx1[2:0]];
        else
            bit_val = pf2_q[idx2[2:0]];
    end

    always_comb begin
        state_nx     = state;
        sub_nx       = sub;
        pos_nx       = pos;
        half_nx      = half;
        pf_nx        = pf;
        pf_bit_nx    = pf_bit;
        pf_right_nx  = pf_right;
        line_done_nx = 1'b0;

        case (state)
            IDLE, DONE: begin
                sub_nx      = '0;
                pos_nx      = '0;
                half_nx     = 1'b0;
                pf_nx       = 1'b0;
                pf_bit_nx   = '0;
                pf_right_nx = 1'b0;
            end
            default: ;
        endcase

        // The first enabled clk out of IDLE already emits pixel 0.
        if ((state == ACTIVE || state == IDLE) && pix_en) begin
            pf_nx       = bit_val;
            pf_bit_nx   = n_sel;
            pf_right_nx = half;
            state_nx    = ACTIVE;
            if (sub == 2'd3) begin
                sub_nx = '0;
                if (pos == 5'd19) begin
                    pos_nx  = '0;
                    half_nx = 1'b1;
                end else begin
                    pos_nx = pos + 5'd1;
                end
            end else begin
                sub_nx = sub + 2'd1;
            end
            if (state == ACTIVE && half && pos == 5'd19 && sub == 2'd3) begin
                state_nx     = DONE;
                line_done_nx = 1'b1;
            end
        end

        // Blanking wins over everything, including a line in progress.
        if (hblank) begin
            state_nx     = IDLE;
            sub_nx       = '0;
            pos_nx       = '0;
            half_nx      = 1'b0;
            pf_nx        = 1'b0;
            pf_bit_nx    = '0;
            pf_right_nx  = 1'b0;
            line_done_nx = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            sub       <= '0;
            pos       <= '0;
            half      <= 1'b0;
            pf        <= 1'b0;
            pf_bit    <= '0;
            pf_right  <= 1'b0;
            line_done <= 1'b0;
        end else begin
            state     <= state_nx;
            sub       <= sub_nx;
            pos       <= pos_nx;
            half      <= half_nx;
            pf        <= pf_nx;
            pf_bit    <= pf_bit_nx;
            pf_right  <= pf_right_nx;
            line_done <= line_done_nx;
        end
    end

endmodule

// File: tb/tb_tia_playfield_serializer.sv
// Bench for tia_playfield_serializer: directed and random lines scored against
// a per-pixel model derived from playfield geometry.
module tb_tia_playfield_serializer;

    logic       clk = 1'b0;
    logic       reset;
    logic       pix_en, hblank;
    logic       pf0_we, pf1_we, pf2_we, ctrlpf_we;
    logic [7:0] wdata;
    logic       pf, pf_right, line_done;
    logic [4:0] pf_bit;
    logic [1:0] fsm_state;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] m_pf0, m_pf1, m_pf2;
    logic       m_ref;
    logic [6:0] exp_q[$];
    int         ones_seen;

    tia_playfield_serializer dut (
        .clk(clk), .reset(reset), .pix_en(pix_en), .hblank(hblank),
        .pf0_we(pf0_we), .pf1_we(pf1_we), .pf2_we(pf2_we), .ctrlpf_we(ctrlpf_we),
        .wdata(wdata), .pf(pf), .pf_bit(pf_bit), .pf_right(pf_right),
        .line_done(line_done), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    // Returns {right, index[4:0], pixel} for pixel p of a line.
    function automatic logic [6:0] model_pix(input int p, input logic [7:0] r0,
                                             input logic [7:0] r1, input logic [7:0] r2,
                                             input logic rf);
        logic [19:0] bits;
        int pos, n;
        logic right;
        for (int k = 0; k < 4; k++)  bits[k] = r0[4 + k];
        for (int k = 4; k < 12; k++) bits[k] = r1[11 - k];
        for (int k = 12; k < 20; k++) bits[k] = r2[k - 12];
        right = (p >= 80);
        pos   = (p % 80) / 4;
        n     = (right && rf) ? 19 - pos : pos;
        return {right, 5'(n), bits[n]};
    endfunction

    task automatic write_reg(input int sel, input logic [7:0] val);
        @(negedge clk);
        wdata = val;
        pf0_we = (sel == 0); pf1_we = (sel == 1); pf2_we = (sel == 2); ctrlpf_we = (sel == 3);
        @(posedge clk); #1;
        pf0_we = 0; pf1_we = 0; pf2_we = 0; ctrlpf_we = 0;
        case (sel)
            0: m_pf0 = val;
            1: m_pf1 = val;
            2: m_pf2 = val;
            default: m_ref = val[0];
        endcase
    endtask

    task automatic set_regs(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic r);
        write_reg(0, a); write_reg(1, b); write_reg(2, c); write_reg(3, {7'd0, r});
    endtask

    // mode: 0 constant enable, 1 toggling, 2 random. wr_at/abort_at/rst_at < 0 disables.
    task automatic run_line(input int mode, input int wr_at, input logic [7:0] wr_val,
                            input int abort_at, input int rst_at);
        int p, cyc, ended;
        logic en, tog, last_pf, last_right;
        logic [4:0] last_bit;
        logic [6:0] item;
        exp_q.delete();
        for (int i = 0; i < 160; i++)
            exp_q.push_back((wr_at >= 0 && i > wr_at) ? model_pix(i, m_pf0, wr_val, m_pf2, m_ref)
                                                      : model_pix(i, m_pf0, m_pf1, m_pf2, m_ref));
        p = 0; cyc = 0; ended = 0; tog = 1'b1; ones_seen = 0;
        last_pf = 1'b0; last_bit = '0; last_right = 1'b0;
        @(negedge clk);
        hblank = 1'b0;
        while (ended == 0 && cyc < 1000) begin
            cyc++;
            case (mode)
                0: en = 1'b1;
                1: begin en = tog; tog = ~tog; end
                default: en = 1'($urandom_range(0, 1));
            endcase
            if (p == abort_at) begin
                hblank = 1'b1; pix_en = 1'b1;
                @(posedge clk); #1;
                check("abort_pf", {7'd0, pf}, 8'd0);
                check("abort_bit", {3'd0, pf_bit}, 8'd0);
                check("abort_done", {7'd0, line_done}, 8'd0);
                repeat (3) begin
                    @(posedge clk); #1;
                    check("abort_no_done", {7'd0, line_done}, 8'd0);
                end
                ended = 2;
            end else if (p == rst_at) begin
                pix_en = 1'b1;
                #2 reset = 1'b1;
                #1;
                check("arst_pf", {7'd0, pf}, 8'd0);
                check("arst_bit", {3'd0, pf_bit}, 8'd0);
                check("arst_right", {7'd0, pf_right}, 8'd0);
                @(negedge clk);
                reset = 1'b0; hblank = 1'b1;
                m_pf0 = 0; m_pf1 = 0; m_pf2 = 0; m_ref = 0;
                ended = 2;
            end else begin
                if (en && p == wr_at) begin
                    pf1_we = 1'b1; wdata = wr_val;
                end
                pix_en = en;
                @(posedge clk); #1;
                pf1_we = 1'b0;
                if (en) begin
                    item = exp_q.pop_front();
                    check($sformatf("pf[%0d]", p), {7'd0, pf}, {7'd0, item[0]});
                    check($sformatf("bit[%0d]", p), {3'd0, pf_bit}, {3'd0, item[5:1]});
                    check($sformatf("right[%0d]", p), {7'd0, pf_right}, {7'd0, item[6]});
                    if (pf) ones_seen++;
                    p++;
                    check($sformatf("done[%0d]", p), {7'd0, line_done}, {7'd0, p == 160});
                    if (p == 160) ended = 1;
                end else begin
                    check("hold_pf", {7'd0, pf}, {7'd0, last_pf});
                    check("hold_bit", {3'd0, pf_bit}, {3'd0, last_bit});
                    check("hold_right", {7'd0, pf_right}, {7'd0, last_right});
                    check("hold_done", {7'd0, line_done}, 8'd0);
                end
                last_pf = pf; last_bit = pf_bit; last_right = pf_right;
                @(negedge clk);
            end
        end
        if (ended == 0) check("line_timeout", 8'd0, 8'd1);
        if (ended == 1) begin
            if (wr_at >= 0) m_pf1 = wr_val;
            pix_en = 1'b1;
            @(posedge clk); #1;
            check("after_pf", {7'd0, pf}, 8'd0);
            check("after_bit", {3'd0, pf_bit}, 8'd0);
            check("after_right", {7'd0, pf_right}, 8'd0);
            check("after_done", {7'd0, line_done}, 8'd0);
        end
        @(negedge clk);
        hblank = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; pix_en = 1'b0; hblank = 1'b1; wdata = '0;
        pf0_we = 0; pf1_we = 0; pf2_we = 0; ctrlpf_we = 0;
        m_pf0 = 0; m_pf1 = 0; m_pf2 = 0; m_ref = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_pf", {7'd0, pf}, 8'd0);
        check("rst_bit", {3'd0, pf_bit}, 8'd0);
        check("rst_right", {7'd0, pf_right}, 8'd0);
        check("rst_done", {7'd0, line_done}, 8'd0);
        @(negedge clk);
        reset = 1'b0;

        set_regs(8'hF0, 8'h00, 8'h00, 1'b0);
        run_line(0, -1, 8'h00, -1, -1);
        check("ones_ref0", 8'(ones_seen), 8'd32);
        set_regs(8'hF0, 8'h00, 8'h00, 1'b1);
        run_line(0, -1, 8'h00, -1, -1);
        check("ones_ref1", 8'(ones_seen), 8'd32);
        set_regs(8'h00, 8'h00, 8'h80, 1'b0);
        run_line(0, -1, 8'h00, -1, -1);
        set_regs(8'h00, 8'h80, 8'h00, 1'b0);
        run_line(0, -1, 8'h00, -1, -1);
        set_regs(8'h00, 8'hFF, 8'h00, 1'b0);
        run_line(1, -1, 8'h00, -1, -1);
        set_regs(8'h00, 8'h00, 8'h00, 1'b0);
        run_line(0, 20, 8'hFF, -1, -1);
        set_regs(8'hA0, 8'h5A, 8'hC3, 1'b1);
        run_line(0, -1, 8'h00, 50, -1);
        run_line(0, -1, 8'h00, -1, -1);
        for (int t = 0; t < 6; t++) begin
            set_regs(8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
            run_line(2, -1, 8'h00, -1, -1);
        end
        set_regs(8'hF0, 8'hFF, 8'hFF, 1'b1);
        run_line(0, -1, 8'h00, -1, 100);
        run_line(0, -1, 8'h00, -1, -1);
        check("zero_after_arst", 8'(ones_seen), 8'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
